csr_tohost_drain: RTL and testbench

- Receiving end of the pipeline's CSR write port.
- Snoops the CSR write strobe and address driven from the execute stage, and captures every write to the tohost CSR.
- Buffers captured values in a small FIFO and drains them to the host or testbench over a valid/ready handshake.
- Latches the riscv-tests style pass/fail verdict from the first nonzero write.

---
 rtl/csr_tohost_drain.sv | 110 +++++++++++
 tb/tb_csr_tohost_drain.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_tohost_drain.sv
// csr_tohost_drain: snoops CSR writes from the execute stage and captures every
// write to the tohost CSR. Captured values are queued in a small circular FIFO
// and drained over a valid/ready handshake. The first nonzero write latches a
// riscv-tests style pass/fail verdict.
module csr_tohost_drain #(
  parameter int          DWIDTH   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [11:0] CSR_ADDR = 12'h51E,
  parameter int          CWIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_we,
  input  logic [11:0]       csr_addr,
  input  logic [DWIDTH-1:0] csr_data_in,
  output logic              host_valid,
  input  logic              host_ready,
  output logic [DWIDTH-1:0] host_data,
  output logic              done,
  output logic              pass,
  output logic [DWIDTH-2:0] fail_code,
  output logic              overflow,
  output logic [CWIDTH-1:0] wr_count
);

  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]     OCC_FULL = (PW+1)'(DEPTH);
  localparam logic [DWIDTH-1:0] ONE    = DWIDTH'(1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       occ;

  logic capture;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // Saturating increment so the counter sticks at all-ones instead of wrapping.
  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + CWIDTH'(1);
  endfunction

  // A value of 1 means pass; anything else carries the failing test number
  // in the upper bits, with bit 0 being the "done" marker of the convention.
  function automatic logic [DWIDTH-2:0] fail_of(input logic [DWIDTH-1:0] data);
    fail_of = (data == ONE) ? '0 : data[DWIDTH-1:1];
  endfunction

  // Event decode: a capture into a full FIFO survives only if the head leaves
  // on the same edge, otherwise it is dropped and flagged.
  always_comb begin
    capture = csr_we && (csr_addr == CSR_ADDR);
    full    = (occ == OCC_FULL);
    pop     = (occ != '0) && host_ready;
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
  end

  assign host_valid = (occ != '0);
  assign host_data  = mem[rd_ptr];

  // FIFO storage, pointers, occupancy, overflow flag and accepted-write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
      wr_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= csr_data_in;
        wr_ptr      <= wr_ptr + PW'(1);
        wr_count    <= sat_inc(wr_count);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        occ <= occ + (PW+1)'(1);
      end else if (pop && !push) begin
        occ <= occ - (PW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Verdict latch: the first nonzero capture (kept or dropped) decides it,
  // after which it is frozen until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
    end else if (capture && !done && (csr_data_in != '0)) begin
      done      <= 1'b1;
      pass      <= (csr_data_in == ONE);
      fail_code <= fail_of(csr_data_in);
    end
  end

endmodule

// File: tb/tb_csr_tohost_drain.sv
// tb_csr_tohost_drain: directed vectors with hand-computed expectations for
// csr_tohost_drain at its default parameters (DWIDTH=32, DEPTH=4).
module tb_csr_tohost_drain;

  logic        clk;
  logic        rst_n;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_data_in;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] host_data;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic        overflow;
  logic [15:0] wr_count;

  int n_vec  = 0;
  int n_miss = 0;

  csr_tohost_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_data_in(csr_data_in),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code),
    .overflow   (overflow),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_we      = 1'b1;
    csr_addr    = addr;
    csr_data_in = data;
    tick();
    csr_we      = 1'b0;
  endtask

  task automatic do_reset();
    csr_we     = 1'b0;
    host_ready = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    csr_we      = 1'b1;
    csr_addr    = 12'h51E;
    csr_data_in = 32'd5;
    host_ready  = 1'b0;

    // Reset held while a tohost write toggles on the inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      csr_data_in = (i % 2 == 0) ? 32'd0 : 32'd5;
    end
    chk("rst_valid",    32'(host_valid), 32'd0);
    chk("rst_data",     host_data,       32'd0);
    chk("rst_done",     32'(done),       32'd0);
    chk("rst_pass",     32'(pass),       32'd0);
    chk("rst_failcode", 32'(fail_code),  32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_wrcount",  32'(wr_count),   32'd0);
    csr_we = 1'b0;
    rst_n  = 1'b1;
    tick();
    tick();
    chk("post_rst_valid",   32'(host_valid), 32'd0);
    chk("post_rst_wrcount", 32'(wr_count),   32'd0);

    // Single pass write, held at the head until the host takes it
    wr(12'h51E, 32'h1);
    chk("pass_valid",    32'(host_valid), 32'd1);
    chk("pass_data",     host_data,       32'd1);
    chk("pass_done",     32'(done),       32'd1);
    chk("pass_pass",     32'(pass),       32'd1);
    chk("pass_failcode", 32'(fail_code),  32'd0);
    chk("pass_wrcount",  32'(wr_count),   32'd1);
    tick();
    chk("pass_hold",     32'(host_valid), 32'd1);
    host_ready = 1'b1;
    tick();
    host_ready = 1'b0;
    chk("pass_drained",  32'(host_valid), 32'd0);

    // Fail code from 7, frozen across a later write of 1
    do_reset();
    wr(12'h51E, 32'h7);
    chk("fail_done",     32'(done),      32'd1);
    chk("fail_pass",     32'(pass),      32'd0);
    chk("fail_code",     32'(fail_code), 32'd3);
    wr(12'h51E, 32'h1);
    chk("fail_done2",    32'(done),      32'd1);
    chk("fail_pass2",    32'(pass),      32'd0);
    chk("fail_code2",    32'(fail_code), 32'd3);
    chk("fail_wrcount",  32'(wr_count),  32'd2);
    chk("fail_head0",    host_data,      32'd7);
    host_ready = 1'b1;
    tick();
    chk("fail_head1",    host_data,      32'd1);
    chk("fail_valid1",   32'(host_valid), 32'd1);
    tick();
    host_ready = 1'b0;
    chk("fail_empty",    32'(host_valid), 32'd0);

    // Address filter and write-enable gating
    do_reset();
    wr(12'h51F, 32'hFF);
    wr(12'h300, 32'hFF);
    csr_addr    = 12'h51E;
    csr_data_in = 32'hFF;
    csr_we      = 1'b0;
    tick();
    chk("filt_valid",   32'(host_valid), 32'd0);
    chk("filt_wrcount", 32'(wr_count),   32'd0);
    chk("filt_done",    32'(done),       32'd0);

    // Zero write into an empty FIFO with host_ready already high
    host_ready = 1'b1;
    wr(12'h51E, 32'h0);
    chk("zero_valid",   32'(host_valid), 32'd1);
    chk("zero_data",    host_data,       32'd0);
    chk("zero_done",    32'(done),       32'd0);
    chk("zero_wrcount", 32'(wr_count),   32'd1);
    tick();
    host_ready = 1'b0;
    chk("zero_drained", 32'(host_valid), 32'd0);

    // Fill to DEPTH and overflow with a fifth write
    do_reset();
    for (int i = 0; i < 4; i++) wr(12'h51E, 32'(10 + i));
    chk("ovf_notyet",   32'(overflow), 32'd0);
    wr(12'h51E, 32'd14);
    chk("ovf_flag",     32'(overflow),  32'd1);
    chk("ovf_wrcount",  32'(wr_count),  32'd4);
    chk("ovf_failcode", 32'(fail_code), 32'd5);
    host_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", host_data, 32'(10 + i));
      tick();
    end
    host_ready = 1'b0;
    chk("ovf_empty",  32'(host_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow),   32'd1);

    // Full FIFO with a capture and pop on the same edge
    do_reset();
    for (int i = 1; i <= 4; i++) wr(12'h51E, 32'(i));
    chk("fp_wrcount4", 32'(wr_count), 32'd4);
    host_ready = 1'b1;
    wr(12'h51E, 32'd5);
    chk("fp_overflow", 32'(overflow), 32'd0);
    chk("fp_wrcount5", 32'(wr_count), 32'd5);
    chk("fp_pass",     32'(pass),     32'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("fp_drain", host_data, 32'(i));
      tick();
    end
    host_ready = 1'b0;
    chk("fp_empty", 32'(host_valid), 32'd0);

    // Reset mid-operation flushes entries and clears sticky flags
    wr(12'h51E, 32'd9);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(host_valid), 32'd0);
    chk("mid_rst_done",  32'(done),       32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_wrcount", 32'(wr_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
